pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the pipelined MIPS core. It replaces the plain PC register with several additions: configurable width, reset vector and increment; stall hold; prioritised redirect and exception vectoring; an EPC capture register; a post-reset boot hold counter; and an optional return-address stack (RAS) for call/return prediction. It sits at the head of the fetch stage and drives the instruction-memory address.

## Interface
- WIDTH, 32, PC and address width in bits
- RESET_VECTOR, 0, PC value loaded on reset
- EXC_VECTOR, 32'd4, PC value loaded on exception
- INC, 1, sequential increment (word-addressed imem)
- BOOT_CYCLES, 2, cycles PC is held at RESET_VECTOR after reset release (≥1)
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold PC (fetch back-pressure)
- redirect_valid  in  1  branch/jump resolved taken
- redirect_target  in  WIDTH  redirect destination
- exc  in  1  exception request
- call  in  1  current fetch is a jal; push return address
- ret  in  1  current fetch is a jr $ra; pop
- pc_out  out  WIDTH  registered current PC
- pc_next  out  WIDTH  combinational next-PC value
- epc  out  WIDTH  PC captured at the last exception
- busy  out  1  high while in the BOOT state
- ras_top  out  WIDTH  top-of-stack return address
- ras_valid  out  1  stack non-empty
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid entries

## Operation
- FSM states: BOOT and RUN.
- On rst: state=BOOT, boot counter=0, pc_out=RESET_VECTOR, epc=0, RAS empty (ras_count=0, ras_valid=0, ras_top=0).
- BOOT: pc_out holds; the counter increments each cycle. When the counter reaches BOOT_CYCLES-1, state moves to RUN. All other inputs are ignored. busy=1.
- RUN: pc_next is selected by priority, highest first:
  - exc: EXC_VECTOR; epc<=pc_out.
  - redirect_valid: redirect_target.
  - stall: pc_out (hold).
  - otherwise: pc_out+INC.
- Arithmetic is modulo 2^WIDTH. PC wraps from all-ones to 0 with no flag.
- exc and redirect override stall. A flush always wins over back-pressure.
- RAS operations are qualified by advance = RUN & !stall & !exc & !redirect_valid.
  - call only: push pc_out+INC. When full, overwrite the oldest entry (circular); count saturates at RAS_DEPTH.
  - ret only: pop when non-empty. When empty, no change.
  - call & ret together: replace the top with pc_out+INC; count unchanged. If empty, behave as a push.
- ret does not change pc_next. Prediction consumption belongs to the fetch stage through ras_top.

## Timing
- pc_out, epc, RAS and FSM state are registered and update on the rising clk edge.
- pc_next is combinational from current state and inputs; zero latency.
- Redirect or exc asserted in cycle N gives the new pc_out in cycle N+1.
- After rst deasserts, the first increment appears BOOT_CYCLES+1 edges later.
- rst mid-operation forces all outputs to reset values immediately (asynchronous), including during BOOT.
- ras_top and ras_count reflect a push or pop one cycle after the qualifying edge.

## Configuration
- PC_RAS_EN defined: the RAS is compiled in as described above.
- PC_RAS_EN undefined: no RAS storage is built. ras_top=0, ras_valid=0, ras_count=0 constantly; call and ret are ignored. All PC behaviour is identical.

## Test plan
- Reset/boot, BOOT_CYCLES=2, RESET_VECTOR=0x100. Release rst. Required: pc_out=0x100 for 2 cycles with busy=1, then 0x101, 0x102.
- Stall vs redirect, pc_out=0x10. stall=1 for 3 cycles: pc_out holds 0x10. Then stall=1 with redirect_valid=1, target 0x40: next pc_out=0x40.
- Exception priority, pc_out=0x20. exc=1 and redirect_valid=1 (target 0x80) in the same cycle. Required: pc_out=0x4 and epc=0x20.
- Wrap-around, WIDTH=8, pc_out=0xFF. Required: next pc_out=0x00.
- RAS overflow/underflow, depth 4, PC_RAS_EN defined. Six calls at PC 0..5. Required: ras_count=4 and ras_top=6. Then five rets. Required: tops 5,4,3, ras_count reaches 0 after the 4th ret, and the 5th ret leaves ras_count=0 with ras_valid=0.
- Simultaneous call+ret, stack {0x11}, pc_out=0x30. Required: ras_top=0x31, ras_count=1. Same test with PC_RAS_EN undefined: ras_count stays 0.

Source files
------------

// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-side bundle for the program-counter unit.
// The master (fetch/pipeline control) drives the control inputs, and the
// slave (pc_unit) returns the PC, EPC, boot status and return-address stack view.
interface pc_unit_if #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic             stall;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             exc;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] epc;
    logic             busy;
    logic [WIDTH-1:0] ras_top;
    logic             ras_valid;
    logic [CW-1:0]    ras_count;

    modport master (
        output stall, redirect_valid, redirect_target, exc, call, ret,
        input  pc_out, pc_next, epc, busy, ras_top, ras_valid, ras_count
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, exc, call, ret,
        output pc_out, pc_next, epc, busy, ras_top, ras_valid, ras_count
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter for the head of the fetch stage.
// Next-PC priority in RUN is exc > redirect > stall > sequential increment.
// A BOOT state holds the reset vector for BOOT_CYCLES cycles after reset.
// The EPC register captures pc_out whenever an exception is taken.
// Optional feature macro: PC_RAS_EN. When it is defined, a circular
// return-address stack is built. When it is undefined, the ras_* outputs are tied to zero.
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'd4),
    parameter logic [WIDTH-1:0] INC          = WIDTH'(32'd1),
    parameter int               BOOT_CYCLES  = 2,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic      clk,
    input  logic      rst,
    pc_unit_if.slave  bus
);
    localparam int CW  = $clog2(RAS_DEPTH) + 1;
    localparam int BCW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [BCW-1:0]   boot_cnt_r;
    logic [BCW-1:0]   boot_cnt_nx_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_next_s;
    logic [WIDTH-1:0] epc_r;
    logic             epc_load_s;
    logic             advance_s;

    // FSM state and boot counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_BOOT;
            boot_cnt_r <= {BCW{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            boot_cnt_r <= boot_cnt_nx_s;
        end
    end

    // Next-state logic and next-PC priority selection
    always_comb begin
        state_nx_s    = state_r;
        boot_cnt_nx_s = boot_cnt_r;
        pc_next_s     = pc_r;
        epc_load_s    = 1'b0;
        advance_s     = 1'b0;
        case (state_r)
            ST_BOOT: begin
                // The counter is left at its last value after BOOT; it is not used in RUN.
                if (boot_cnt_r == BOOT_LAST) begin
                    state_nx_s = ST_RUN;
                end else begin
                    boot_cnt_nx_s = boot_cnt_r + BCW'(1'b1);
                end
            end
            ST_RUN: begin
                if (bus.exc) begin
                    pc_next_s  = EXC_VECTOR;
                    epc_load_s = 1'b1;
                end else if (bus.redirect_valid) begin
                    pc_next_s = bus.redirect_target;
                end else if (bus.stall) begin
                    pc_next_s = pc_r;
                end else begin
                    pc_next_s = pc_r + INC;
                    advance_s = 1'b1;
                end
            end
            default: begin
                state_nx_s = ST_BOOT;
            end
        endcase
    end

    // PC and exception-PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r  <= RESET_VECTOR;
            epc_r <= {WIDTH{1'b0}};
        end else begin
            pc_r <= pc_next_s;
            if (epc_load_s) begin
                epc_r <= pc_r;
            end
        end
    end

    assign bus.pc_out  = pc_r;
    assign bus.pc_next = pc_next_s;
    assign bus.epc     = epc_r;
    assign bus.busy    = (state_r == ST_BOOT);

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
    logic [PW-1:0]    ras_sp_r;        // slot that the next push writes
    logic [CW-1:0]    ras_cnt_r;
    logic [PW-1:0]    ras_top_idx_s;
    logic [WIDTH-1:0] ret_addr_s;
    logic             push_s;
    logic             pop_s;
    logic             repl_s;

    assign ret_addr_s    = pc_r + INC;
    assign ras_top_idx_s = ras_sp_r - PW'(1'b1);

    // Decode call/ret into stack operations, gated by a sequential advance
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        repl_s = 1'b0;
        if (advance_s) begin
            if (bus.call && bus.ret) begin
                if (ras_cnt_r == {CW{1'b0}}) begin
                    push_s = 1'b1;
                end else begin
                    repl_s = 1'b1;
                end
            end else if (bus.call) begin
                push_s = 1'b1;
            end else if (bus.ret) begin
                if (ras_cnt_r != {CW{1'b0}}) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end else begin
                push_s = 1'b0;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Stack pointer and occupancy; a push onto a full stack overwrites the oldest entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_sp_r  <= {PW{1'b0}};
            ras_cnt_r <= {CW{1'b0}};
        end else if (push_s) begin
            ras_sp_r <= ras_sp_r + PW'(1'b1);
            if (ras_cnt_r != CW'(RAS_DEPTH)) begin
                ras_cnt_r <= ras_cnt_r + CW'(1'b1);
            end
        end else if (pop_s) begin
            ras_sp_r  <= ras_sp_r - PW'(1'b1);
            ras_cnt_r <= ras_cnt_r - CW'(1'b1);
        end
    end

    // Return-address storage (occupancy masks stale slots, so no reset is needed)
    always_ff @(posedge clk) begin
        if (push_s) begin
            ras_mem_r[ras_sp_r] <= ret_addr_s;
        end else if (repl_s) begin
            ras_mem_r[ras_top_idx_s] <= ret_addr_s;
        end
    end

    assign bus.ras_count = ras_cnt_r;
    assign bus.ras_valid = (ras_cnt_r != {CW{1'b0}});
    assign bus.ras_top   = (ras_cnt_r != {CW{1'b0}}) ? ras_mem_r[ras_top_idx_s] : {WIDTH{1'b0}};
`else
    logic unused_ras_s;
    assign unused_ras_s  = bus.call ^ bus.ret ^ advance_s;
    assign bus.ras_count = {CW{1'b0}};
    assign bus.ras_valid = 1'b0;
    assign bus.ras_top   = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: self-checking bench for pc_unit.
// It uses a 16-bit instance for the main tests and an 8-bit instance for the wrap test.
// The reference model works in plain integers, and it models the return-address stack as a queue.
module tb_pc_unit;
    localparam int W  = 16;
    localparam int RD = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_unit_if #(.WIDTH(W), .RAS_DEPTH(RD)) bus16 ();
    pc_unit_if #(.WIDTH(8), .RAS_DEPTH(RD)) bus8 ();

    pc_unit #(.WIDTH(W), .RESET_VECTOR(16'h0100), .EXC_VECTOR(16'h0004),
              .INC(16'h0001), .BOOT_CYCLES(2), .RAS_DEPTH(RD))
        dut (.clk(clk), .rst(rst), .bus(bus16));

    pc_unit #(.WIDTH(8), .RESET_VECTOR(8'hF0), .EXC_VECTOR(8'h04),
              .INC(8'h01), .BOOT_CYCLES(1), .RAS_DEPTH(RD))
        dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned      m_pc;
    int unsigned      m_epc;
    bit               m_run;
    int               m_boot_left;
    logic [W-1:0]     m_ras[$];

    function automatic void m_reset();
        m_pc = 32'h100;
        m_epc = 32'h0;
        m_run = 1'b0;
        m_boot_left = 2;
        m_ras.delete();
    endfunction

    function automatic int unsigned m_next(bit st, bit rv, int unsigned tg, bit ex);
        if (!m_run) return m_pc;
        if (ex) return 32'h4;
        if (rv) return tg & 32'hFFFF;
        if (st) return m_pc;
        return (m_pc + 32'd1) & 32'hFFFF;
    endfunction

    function automatic void m_step(bit st, bit rv, int unsigned tg, bit ex, bit cl, bit rt);
        int unsigned npc;
        logic [W-1:0] ra;
        npc = m_next(st, rv, tg, ex);
        ra = W'(m_pc + 32'd1);
        if (!m_run) begin
            m_boot_left--;
            if (m_boot_left == 0) m_run = 1'b1;
        end else begin
            if (ex) m_epc = m_pc;
            if (RAS_ON && !st && !ex && !rv) begin
                if (cl && rt) begin
                    if (m_ras.size() == 0) m_ras.push_back(ra);
                    else m_ras[m_ras.size() - 1] = ra;
                end else if (cl) begin
                    m_ras.push_back(ra);
                    if (m_ras.size() > RD) void'(m_ras.pop_front());
                end else if (rt && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
        end
        m_pc = npc;
    endfunction

    function automatic int unsigned m_top();
        if (m_ras.size() == 0) return 32'h0;
        return 32'(m_ras[m_ras.size() - 1]);
    endfunction

    task automatic check_all();
        chk("pc_out", 32'(bus16.pc_out), m_pc);
        chk("epc", 32'(bus16.epc), m_epc);
        chk("busy", 32'(bus16.busy), 32'(!m_run));
        chk("ras_count", 32'(bus16.ras_count), m_ras.size());
        chk("ras_valid", 32'(bus16.ras_valid), 32'(m_ras.size() != 0));
        chk("ras_top", 32'(bus16.ras_top), m_top());
    endtask

    // Apply one cycle of inputs. The task is entered and left just after a negedge.
    task automatic drive(input bit st, input bit rv, input int unsigned tg,
                         input bit ex, input bit cl, input bit rt);
        bus16.stall = st;
        bus16.redirect_valid = rv;
        bus16.redirect_target = W'(tg);
        bus16.exc = ex;
        bus16.call = cl;
        bus16.ret = rt;
        #1;
        chk("pc_next", 32'(bus16.pc_next), m_next(st, rv, tg, ex));
        @(posedge clk);
        m_step(st, rv, tg, ex, cl, rt);
        #1;
        check_all();
        @(negedge clk);
    endtask

    typedef struct {
        bit          st;
        bit          rv;
        logic [15:0] tg;
        bit          ex;
        logic [15:0] exp_pc;
        logic [15:0] exp_epc;
    } vec_t;

    vec_t tbl[11];
    int unsigned ret_top[5];
    int unsigned ret_cnt[5];

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 16'h0010, 1'b0, 16'h0010, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0010, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0010, 16'h0000};
        tbl[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0010, 16'h0000};
        tbl[4]  = '{1'b1, 1'b1, 16'h0040, 1'b0, 16'h0040, 16'h0000};
        tbl[5]  = '{1'b0, 1'b1, 16'h0020, 1'b0, 16'h0020, 16'h0000};
        tbl[6]  = '{1'b0, 1'b1, 16'h0080, 1'b1, 16'h0004, 16'h0020};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0005, 16'h0020};
        tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0005};
        tbl[9]  = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 16'hFFFF, 16'h0005};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0005};
        ret_top = '{32'd5, 32'd4, 32'd3, 32'd0, 32'd0};
        ret_cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};

        bus16.stall = 1'b0; bus16.redirect_valid = 1'b0; bus16.redirect_target = 16'h0;
        bus16.exc = 1'b0; bus16.call = 1'b0; bus16.ret = 1'b0;
        bus8.stall = 1'b0; bus8.redirect_valid = 1'b0; bus8.redirect_target = 8'h0;
        bus8.exc = 1'b0; bus8.call = 1'b0; bus8.ret = 1'b0;

        // Reset values
        m_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_pc", 32'(bus16.pc_out), 32'h100);
        rst = 1'b0;

        // Boot: hold 0x100 for two busy cycles, then one idle RUN cycle, then increment
        drive(0, 0, 0, 0, 0, 0);
        chk("boot1_busy", 32'(bus16.busy), 32'h1);
        drive(0, 0, 0, 0, 0, 0);
        chk("boot2_pc", 32'(bus16.pc_out), 32'h100);
        chk("boot2_busy", 32'(bus16.busy), 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        chk("boot3_pc", 32'(bus16.pc_out), 32'h101);
        drive(0, 0, 0, 0, 0, 0);
        chk("boot4_pc", 32'(bus16.pc_out), 32'h102);

        // Table: stall/redirect/exception priority and 16-bit wrap
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].st, tbl[i].rv, 32'(tbl[i].tg), tbl[i].ex, 0, 0);
            chk($sformatf("tbl%0d_pc", i), 32'(bus16.pc_out), 32'(tbl[i].exp_pc));
            chk($sformatf("tbl%0d_epc", i), 32'(bus16.epc), 32'(tbl[i].exp_epc));
        end

        // Asynchronous reset in mid-cycle, then inputs ignored during BOOT
        #2 rst = 1'b1;
        #1;
        chk("arst_pc", 32'(bus16.pc_out), 32'h100);
        chk("arst_epc", 32'(bus16.epc), 32'h0);
        chk("arst_busy", 32'(bus16.busy), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        drive(1, 1, 32'h80, 1, 1, 0);
        chk("bootexc_pc", 32'(bus16.pc_out), 32'h100);
        chk("bootexc_epc", 32'(bus16.epc), 32'h0);
        chk("bootexc_ras", 32'(bus16.ras_count), 32'h0);
        drive(0, 0, 0, 0, 0, 0);

        // RAS overflow and underflow
        drive(0, 1, 32'h0, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 1, 0);
        chk("ovf_count", 32'(bus16.ras_count), RAS_ON ? 32'd4 : 32'd0);
        chk("ovf_top", 32'(bus16.ras_top), RAS_ON ? 32'd6 : 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            chk($sformatf("ret%0d_top", i), 32'(bus16.ras_top), RAS_ON ? ret_top[i] : 32'd0);
            chk($sformatf("ret%0d_cnt", i), 32'(bus16.ras_count), RAS_ON ? ret_cnt[i] : 32'd0);
        end
        chk("unf_valid", 32'(bus16.ras_valid), 32'h0);

        // Simultaneous call+ret replaces the top entry
        drive(0, 1, 32'h10, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 1, 32'h30, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1);
        chk("cr_top", 32'(bus16.ras_top), RAS_ON ? 32'h31 : 32'h0);
        chk("cr_count", 32'(bus16.ras_count), RAS_ON ? 32'h1 : 32'h0);

        // Randomised run against the model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) == 0, ($urandom % 8) == 0, $urandom & 32'hFFFF,
                  ($urandom % 16) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0);
        end

        // 8-bit instance: wrap from 0xFF to 0x00
        bus8.redirect_valid = 1'b1;
        bus8.redirect_target = 8'hFF;
        @(posedge clk);
        #1;
        chk("w8_pc_ff", 32'(bus8.pc_out), 32'hFF);
        @(negedge clk);
        bus8.redirect_valid = 1'b0;
        #1;
        chk("w8_next", 32'(bus8.pc_next), 32'h00);
        @(posedge clk);
        #1;
        chk("w8_pc_00", 32'(bus8.pc_out), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
